// File: rtl/mmio_uart_pkg.sv
// Shared register map, STATUS bit layout and serializer state encoding for the MMIO UART transmitter.
package mmio_uart_pkg;

   localparam logic [2:0] TXDATA_OFS = 3'd0;
   localparam logic [2:0] STATUS_OFS = 3'd4;

   localparam int ST_FULL      = 0;
   localparam int ST_EMPTY     = 1;
   localparam int ST_BUSY      = 2;
   localparam int ST_OVERFLOW  = 3;
   localparam int ST_COUNT_LSB = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-bus view of the UART: address/strobe/store data in, combinational hit and load data out.
interface mmio_uart_tx_if;
   logic [31:0] bus_address;
   logic [31:0] bus_write_data;
   logic [3:0]  bus_byte_enable;
   logic        bus_write_enable;
   logic        bus_read_enable;
   logic [31:0] bus_read_data;
   logic        hit;

   modport master (
      output bus_address, bus_write_data, bus_byte_enable, bus_write_enable, bus_read_enable,
      input  bus_read_data, hit
   );

   modport slave (
      input  bus_address, bus_write_data, bus_byte_enable, bus_write_enable, bus_read_enable,
      output bus_read_data, hit
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO; head visible combinationally on dout, push/pop take effect at the edge.
// A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
module uart_tx_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    din,
   output logic [7:0]    dout,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA writes queue bytes, STATUS reads return same cycle.
// First start bit appears two cycles after the write; writes to a full FIFO are dropped and flagged.
module mmio_uart_tx
   import mmio_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h1100_0000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 8,
   parameter int          FIFO_AW      = 3
) (
   input  logic           clock,
   input  logic           reset,
   mmio_uart_tx_if.slave  bus,
   output logic           tx_out
);
   localparam int BW = ($clog2(CLKS_PER_BIT) > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic             win;
   logic             sel_status;
   logic             sel_txdata;
   logic             wr_txdata;
   logic             wr_status;
   logic             overflow;
   logic             ovf_set;
   logic [31:0]      status;
   logic [FIFO_AW:0] fifo_count;
   logic [7:0]       fifo_dout;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic             unused_bits;

   tx_state_e        state, state_n;
   logic [BW-1:0]    baud, baud_n;
   logic [2:0]       bit_idx, bit_n;
   logic [7:0]       shift, shift_n;
   logic             tx_n;
   logic             baud_last;

   // Address decode: 8-byte window, bit 2 picks the register, byte offset bits are don't-care.
   assign win        = (bus.bus_address[31:3] == BASE_ADDR[31:3]);
   assign bus.hit    = (bus.bus_read_enable | bus.bus_write_enable) & win;
   assign sel_status = (bus.bus_address[2] == STATUS_OFS[2]);
   assign sel_txdata = (bus.bus_address[2] == TXDATA_OFS[2]);
   assign wr_txdata  = bus.hit & bus.bus_write_enable & bus.bus_byte_enable[0] & sel_txdata;
   assign wr_status  = bus.hit & bus.bus_write_enable & bus.bus_byte_enable[0] & sel_status;
   assign unused_bits = &{1'b0, bus.bus_address[1:0], bus.bus_write_data[31:8],
                          bus.bus_byte_enable[3:1]};

   always_comb begin
      status                          = '0;
      status[ST_FULL]                 = fifo_full;
      status[ST_EMPTY]                = fifo_empty;
      status[ST_BUSY]                 = (state != IDLE);
      status[ST_OVERFLOW]             = overflow;
      status[ST_COUNT_LSB +: 8]       = 8'(fifo_count);
   end

   assign bus.bus_read_data = (bus.hit & sel_status) ? status : 32'h0;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (wr_txdata),
      .pop   (pop),
      .din   (bus.bus_write_data[7:0]),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Set has priority over a simultaneous W1C so a drop is never lost.
   assign ovf_set = wr_txdata & fifo_full & ~pop;

   always_ff @(posedge clock) begin
      if (reset)                                    overflow <= 1'b0;
      else if (ovf_set)                             overflow <= 1'b1;
      else if (wr_status & bus.bus_write_data[3])   overflow <= 1'b0;
   end

   assign baud_last = (baud == BW'(CLKS_PER_BIT - 1));

   always_comb begin
      state_n = state;
      baud_n  = baud;
      bit_n   = bit_idx;
      shift_n = shift;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_n = fifo_dout;
               baud_n  = '0;
               bit_n   = '0;
               state_n = START;
            end
         end
         START: begin
            baud_n = baud + 1'b1;
            if (baud_last) begin
               baud_n  = '0;
               state_n = DATA;
            end
         end
         DATA: begin
            baud_n = baud + 1'b1;
            if (baud_last) begin
               baud_n  = '0;
               shift_n = {1'b0, shift[7:1]};
               bit_n   = bit_idx + 1'b1;
               if (bit_idx == 3'd7) state_n = STOP;
            end
         end
         STOP: begin
            baud_n = baud + 1'b1;
            if (baud_last) begin
               baud_n  = '0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      // Line level is derived from the next state so tx_out can be a plain flop.
      tx_n = 1'b1;
      if (state_n == START)     tx_n = 1'b0;
      else if (state_n == DATA) tx_n = shift_n[0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx_out  <= 1'b1;
      end else begin
         state   <= state_n;
         baud    <= baud_n;
         bit_idx <= bit_n;
         shift   <= shift_n;
         tx_out  <= tx_n;
      end
   end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench: timed expectations for line/bus outputs plus a serial-frame decoder scoreboard.
module tb_mmio_uart_tx;
   localparam logic [31:0] BASE = 32'h1100_0000;
   localparam int          CPB  = 4;
   localparam int          FRAME = 10 * CPB;

   logic clock = 1'b0;
   logic reset;
   logic tx_out;

   mmio_uart_tx_if bus ();

   mmio_uart_tx #(
      .BASE_ADDR    (BASE),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (8),
      .FIFO_AW      (3)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .bus    (bus),
      .tx_out (tx_out)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          c;
      int          kind;    // 0 = tx_out, 1 = hit, 2 = read data
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] byte_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic exp_now(input int kind, input logic [31:0] val, input string name);
      exp_t e;
      e.c = cyc; e.kind = kind; e.val = val; e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic bus_idle();
      bus.bus_address      = 32'h0;
      bus.bus_write_data   = 32'h0;
      bus.bus_byte_enable  = 4'h0;
      bus.bus_write_enable = 1'b0;
      bus.bus_read_enable  = 1'b0;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      bus_idle();
   endtask

   task automatic access(input logic we, input logic re, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
      bus.bus_address      = a;
      bus.bus_write_data   = wd;
      bus.bus_byte_enable  = be;
      bus.bus_write_enable = we;
      bus.bus_read_enable  = re;
      step();
   endtask

   task automatic rd(input logic [31:0] a, input logic h, input logic [31:0] d, input string name);
      exp_now(1, {31'b0, h}, {name, "_hit"});
      exp_now(2, d, {name, "_rdata"});
      access(1'b0, 1'b1, a, 32'h0, 4'h0);
   endtask

   // Timed expectation monitor: compares whatever the stimulus queued for the current cycle.
   exp_t e_mon;
   always @(negedge clock) begin
      while (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
         e_mon = exp_q.pop_front();
         if (e_mon.c < cyc) check({e_mon.name, "_missed"}, cyc, e_mon.c);
         else if (e_mon.kind == 0) check(e_mon.name, {31'b0, tx_out}, e_mon.val);
         else if (e_mon.kind == 1) check(e_mon.name, {31'b0, bus.hit}, e_mon.val);
         else check(e_mon.name, bus.bus_read_data, e_mon.val);
      end
   end

   // Serial decoder: samples mid-bit, pops the expected byte at the stop bit.
   bit         ract = 1'b0;
   int         rcnt = 0;
   logic       prev = 1'b1;
   logic [7:0] rb   = 8'h0;
   logic [7:0] rexp;
   always @(negedge clock) begin
      if (reset === 1'b1) begin
         ract = 1'b0;
      end else if (!ract) begin
         if (prev === 1'b1 && tx_out === 1'b0) begin
            ract = 1'b1;
            rcnt = 0;
         end
      end else begin
         rcnt++;
         if (rcnt == CPB/2) begin
            check("rx_start_bit", {31'b0, tx_out}, 32'h0);
         end else if (rcnt > CPB/2 && rcnt < CPB/2 + 9*CPB && (rcnt - CPB/2) % CPB == 0) begin
            rb[(rcnt - CPB/2) / CPB - 1] = tx_out;
         end else if (rcnt == CPB/2 + 9*CPB) begin
            ract = 1'b0;
            check("rx_stop_bit", {31'b0, tx_out}, 32'h1);
            if (byte_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rx_unexpected_frame: got byte %h, expected no frame", rb);
            end else begin
               rexp = byte_q.pop_front();
               check("rx_byte", {24'b0, rb}, {24'b0, rexp});
            end
         end
      end
      prev = tx_out;
   end

   initial begin
      int c0;
      int k;
      logic [31:0] st;
      logic        tb;

      reset = 1'b1;
      bus_idle();
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;

      // Idle readout
      exp_now(0, 32'h1, "t1_tx_idle");
      rd(BASE + 32'd4, 1'b1, 32'h0000_0002, "t1_status");

      // Lane masking: no push without byte lane 0
      access(1'b1, 1'b0, BASE, 32'h0000_0041, 4'b1110);
      for (int i = 0; i < 6; i++) begin
         exp_now(0, 32'h1, "t4_tx_idle");
         rd(BASE + 32'd4, 1'b1, 32'h0000_0002, "t4_status");
      end

      // Address miss above and below the window
      rd(BASE + 32'd8, 1'b0, 32'h0, "t6_rd_hi");
      exp_now(1, 32'h0, "t6_wr_hi_hit");
      access(1'b1, 1'b0, BASE + 32'd8, 32'h0000_0033, 4'hF);
      exp_now(1, 32'h0, "t6_wr_lo_hit");
      access(1'b1, 1'b0, BASE - 32'd4, 32'h0000_0033, 4'hF);
      rd(BASE - 32'd4, 1'b0, 32'h0, "t6_rd_lo");
      for (int i = 0; i < 4; i++) begin
         exp_now(0, 32'h1, "t6_tx_idle");
         rd(BASE + 32'd4, 1'b1, 32'h0000_0002, "t6_status");
      end

      // Single frame, cycle-exact line and STATUS
      byte_q.push_back(8'h55);
      exp_now(0, 32'h1, "t2_tx");
      access(1'b1, 1'b0, BASE, 32'h0000_0055, 4'b0001);
      for (k = 1; k <= FRAME + 2; k++) begin
         if (k < 2)              tb = 1'b1;
         else if (k < 2 + CPB)   tb = 1'b0;
         else if (k < 2 + 9*CPB) tb = (8'h55 >> ((k - 2 - CPB) / CPB)) & 8'h01;
         else                    tb = 1'b1;
         if (k == 1)              st = 32'h0000_0100;
         else if (k < 2 + FRAME)  st = 32'h0000_0006;
         else                     st = 32'h0000_0002;
         exp_now(0, {31'b0, tb}, "t2_tx");
         rd(BASE + 32'd4, 1'b1, st, "t2_status");
      end

      // Overflow: ten back-to-back pushes, last one dropped
      c0 = cyc;
      for (int i = 0; i < 10; i++) begin
         if (i < 9) byte_q.push_back(8'(i));
         access(1'b1, 1'b0, BASE, 32'(i), 4'b0001);
      end
      rd(BASE + 32'd4, 1'b1, 32'h0000_080D, "t3_status_ovf");
      access(1'b1, 1'b0, BASE + 32'd4, 32'h0000_0008, 4'b0001);
      rd(BASE + 32'd4, 1'b1, 32'h0000_0805, "t3_status_w1c");
      while (cyc < c0 + 9 * (FRAME + 1) + 10) step();
      rd(BASE + 32'd4, 1'b1, 32'h0000_0002, "t3_status_drained");

      // Reset mid-frame with bytes queued; write in the reset cycle is ignored
      c0 = cyc;
      for (int i = 0; i < 4; i++) access(1'b1, 1'b0, BASE, 32'hA1 + 32'(i), 4'b0001);
      while (cyc < c0 + 10) step();
      rd(BASE + 32'd4, 1'b1, 32'h0000_0304, "t5_status_pre");
      reset = 1'b1;
      access(1'b1, 1'b0, BASE, 32'h0000_0077, 4'b0001);
      reset = 1'b0;
      exp_now(0, 32'h1, "t5_tx_after_reset");
      rd(BASE + 32'd4, 1'b1, 32'h0000_0002, "t5_status_after_reset");
      for (int i = 0; i < 6; i++) begin
         repeat (9) step();
         exp_now(0, 32'h1, "t5_tx_quiet");
         rd(BASE + 32'd4, 1'b1, 32'h0000_0002, "t5_status_quiet");
      end

      step();
      check("leftover_rx_bytes", byte_q.size(), 32'h0);
      check("leftover_expectations", exp_q.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
